// File: rtl/tron_pkg.sv
// Shared TRON arena constants, trail-writer FSM states and coordinate-to-address helpers.
// Also used by the VGA trail reader, so the address mapping is defined here only.
package tron_pkg;

  localparam int unsigned GRID_W = 160;
  localparam int unsigned GRID_H = 120;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned CELLS  = GRID_W * GRID_H;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StRd1,
    StRd2,
    StChk2,
    StWr1,
    StWr2
  } trail_state_e;

  // y*160 + x without a multiplier: 160 = 128 + 32.
  function automatic logic [ADDR_W-1:0] coord_to_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction

  function automatic logic coord_in_range(input logic [7:0] x, input logic [6:0] y);
    return (32'(x) < GRID_W) && (32'(y) < GRID_H);
  endfunction

endpackage

// File: rtl/tron_trail_writer.sv
// Write-side controller for the P1/P2 trail BRAMs: per-step head reads for the collision
// checkers, trail writes for live players, and a full zero sweep after reset or on new round.
module tron_trail_writer
  import tron_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              step,
  input  logic              clear_req,
  input  logic [7:0]        p1_x,
  input  logic [6:0]        p1_y,
  input  logic [7:0]        p2_x,
  input  logic [6:0]        p2_y,
  input  logic              p1_alive,
  input  logic              p2_alive,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we_p1,
  output logic              mem_we_p2,
  output logic              mem_wdata,
  output logic              chk_p1_valid,
  output logic              chk_p2_valid,
  output logic              wall_p1,
  output logic              wall_p2,
  output logic              head_on,
  output logic              busy,
  output logic              step_done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] ClrLast = ADDR_W'(CELLS - 1);

  trail_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_pend_q, clr_pend_d;
  logic              overrun_d;

  // Per-step latched head information.
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic              in1_q, in2_q, alive1_q, alive2_q, same_q;

  logic              in1_in, in2_in;
  logic [ADDR_W-1:0] a1_in, a2_in;
  logic              accept, start_clear;

  logic [ADDR_W-1:0] mem_addr_d;
  logic              we1_d, we2_d, wdata_d, chk1_d, chk2_d, wall1_d, wall2_d;
  logic              head_on_d, done_d, busy_d;

  assign in1_in = coord_in_range(p1_x, p1_y);
  assign in2_in = coord_in_range(p2_x, p2_y);
  assign a1_in  = in1_in ? coord_to_addr(p1_x, p1_y) : '0;
  assign a2_in  = in2_in ? coord_to_addr(p2_x, p2_y) : '0;

  // Outputs are registered from the next state, so each output reflects the current state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_pend_d  = clr_pend_q;
    overrun_d   = overrun;
    accept      = 1'b0;
    start_clear = 1'b0;
    mem_addr_d  = '0;
    we1_d       = 1'b0;
    we2_d       = 1'b0;
    wdata_d     = 1'b0;
    chk1_d      = 1'b0;
    chk2_d      = 1'b0;
    wall1_d     = 1'b0;
    wall2_d     = 1'b0;
    head_on_d   = 1'b0;
    done_d      = 1'b0;

    if (state_q inside {StRd1, StRd2, StChk2, StWr1, StWr2}) begin
      if (step)      overrun_d  = 1'b1;
      if (clear_req) clr_pend_d = 1'b1;
    end

    unique case (state_q)
      StClear: begin
        we1_d = 1'b1;
        we2_d = 1'b1;
        // Write enables are still low only in the first cycle after reset: emit address 0.
        if (!mem_we_p1) begin
          mem_addr_d = cnt_q;
        end else if (cnt_q == ClrLast) begin
          state_d = StIdle;
          we1_d   = 1'b0;
          we2_d   = 1'b0;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          mem_addr_d = cnt_d;
        end
      end
      StIdle: begin
        if (clear_req) begin
          start_clear = 1'b1;
        end else if (step) begin
          accept     = 1'b1;
          state_d    = StRd1;
          mem_addr_d = a1_in;
        end
      end
      StRd1: begin
        state_d    = StRd2;
        mem_addr_d = addr2_q;
        chk1_d     = 1'b1;
        wall1_d    = !in1_q;
        head_on_d  = same_q;
      end
      StRd2: begin
        state_d = StChk2;
        chk2_d  = 1'b1;
        wall2_d = !in2_q;
      end
      StChk2: begin
        state_d    = StWr1;
        mem_addr_d = addr1_q;
        wdata_d    = 1'b1;
        we1_d      = alive1_q & in1_q;
      end
      StWr1: begin
        state_d    = StWr2;
        mem_addr_d = addr2_q;
        wdata_d    = 1'b1;
        we2_d      = alive2_q & in2_q;
        done_d     = 1'b1;
      end
      StWr2: begin
        if (clr_pend_q || clear_req) start_clear = 1'b1;
        else                         state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start_clear) begin
      state_d    = StClear;
      cnt_d      = '0;
      clr_pend_d = 1'b0;
      overrun_d  = 1'b0;
      mem_addr_d = '0;
      we1_d      = 1'b1;
      we2_d      = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StClear;
      cnt_q        <= '0;
      clr_pend_q   <= 1'b0;
      overrun      <= 1'b0;
      mem_addr     <= '0;
      mem_we_p1    <= 1'b0;
      mem_we_p2    <= 1'b0;
      mem_wdata    <= 1'b0;
      chk_p1_valid <= 1'b0;
      chk_p2_valid <= 1'b0;
      wall_p1      <= 1'b0;
      wall_p2      <= 1'b0;
      head_on      <= 1'b0;
      step_done    <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_pend_q   <= clr_pend_d;
      overrun      <= overrun_d;
      mem_addr     <= mem_addr_d;
      mem_we_p1    <= we1_d;
      mem_we_p2    <= we2_d;
      mem_wdata    <= wdata_d;
      chk_p1_valid <= chk1_d;
      chk_p2_valid <= chk2_d;
      wall_p1      <= wall1_d;
      wall_p2      <= wall2_d;
      head_on      <= head_on_d;
      step_done    <= done_d;
      busy         <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr1_q  <= '0;
      addr2_q  <= '0;
      in1_q    <= 1'b0;
      in2_q    <= 1'b0;
      alive1_q <= 1'b0;
      alive2_q <= 1'b0;
      same_q   <= 1'b0;
    end else if (accept) begin
      addr1_q  <= a1_in;
      addr2_q  <= a2_in;
      in1_q    <= in1_in;
      in2_q    <= in2_in;
      alive1_q <= p1_alive;
      alive2_q <= p2_alive;
      same_q   <= (p1_x == p2_x) && (p1_y == p2_y);
    end
  end

endmodule

// File: tb/tb_tron_trail_writer.sv
// Scoreboard bench for tron_trail_writer: per-cycle expected output vectors are queued when a
// step is driven and compared by a negedge monitor as the DUT reaches each cycle.
module tb_tron_trail_writer;

  logic        clk, resetn, step, clear_req, p1_alive, p2_alive;
  logic [7:0]  p1_x, p2_x;
  logic [6:0]  p1_y, p2_y;
  logic [14:0] mem_addr;
  logic        mem_we_p1, mem_we_p2, mem_wdata, chk_p1_valid, chk_p2_valid;
  logic        wall_p1, wall_p2, head_on, busy, step_done, overrun;

  tron_trail_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .step         (step),
    .clear_req    (clear_req),
    .p1_x         (p1_x),
    .p1_y         (p1_y),
    .p2_x         (p2_x),
    .p2_y         (p2_y),
    .p1_alive     (p1_alive),
    .p2_alive     (p2_alive),
    .mem_addr     (mem_addr),
    .mem_we_p1    (mem_we_p1),
    .mem_we_p2    (mem_we_p2),
    .mem_wdata    (mem_wdata),
    .chk_p1_valid (chk_p1_valid),
    .chk_p2_valid (chk_p2_valid),
    .wall_p1      (wall_p1),
    .wall_p2      (wall_p2),
    .head_on      (head_on),
    .busy         (busy),
    .step_done    (step_done),
    .overrun      (overrun)
  );

  typedef struct {
    int          cyc;
    int          id;
    int          slot;
    logic [31:0] val;
    logic [31:0] mask;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pk(input int addr, input bit we1, input bit we2, input bit wd,
                                     input bit c1, input bit c2, input bit w1, input bit w2,
                                     input bit ho, input bit dn, input bit bs, input bit ov);
    logic [14:0] a;
    a = addr[14:0];
    return {6'b0, ov, bs, dn, ho, w2, w1, c2, c1, wd, we2, we1, a};
  endfunction

  function automatic logic [31:0] obs();
    return pk(int'(mem_addr), mem_we_p1, mem_we_p2, mem_wdata, chk_p1_valid, chk_p2_valid,
              wall_p1, wall_p2, head_on, step_done, busy, overrun);
  endfunction

  task automatic push(input int c, input int id, input int slot, input logic [31:0] v,
                      input logic [31:0] m);
    sb_t e;
    e.cyc = c; e.id = id; e.slot = slot; e.val = v; e.mask = m;
    sb_q.push_back(e);
  endtask

  // Reference model of one step sequence started in cycle t.
  task automatic push_step(input int id, input int t, input int x1, input int y1, input int x2,
                           input int y2, input bit al1, input bit al2, input logic [4:0] ovr,
                           input bit idle_after);
    bit in1, in2, same;
    int a1, a2;
    in1  = (x1 < 160) && (y1 < 120);
    in2  = (x2 < 160) && (y2 < 120);
    a1   = in1 ? y1 * 160 + x1 : 0;
    a2   = in2 ? y2 * 160 + x2 : 0;
    same = (x1 == x2) && (y1 == y2);
    push(t + 1, id, 1, pk(a1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ovr[0]), '1);
    push(t + 2, id, 2, pk(a2, 0, 0, 0, 1, 0, !in1, 0, same, 0, 1, ovr[1]), '1);
    push(t + 3, id, 3, pk(0, 0, 0, 0, 0, 1, 0, !in2, 0, 0, 1, ovr[2]), ~32'h7fff);
    push(t + 4, id, 4, pk(a1, al1 && in1, 0, 1, 0, 0, 0, 0, 0, 0, 1, ovr[3]), '1);
    push(t + 5, id, 5, pk(a2, 0, al2 && in2, 1, 0, 0, 0, 0, 0, 1, 1, ovr[4]), '1);
    if (idle_after) push(t + 6, id, 6, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), '1);
  endtask

  always @(negedge clk) begin : monitor
    sb_t e;
    if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      if (e.cyc != cyc) check_eq($sformatf("sb_late_s%0d", e.id), cyc, e.cyc);
      else check_eq($sformatf("step%0d_t+%0d", e.id, e.slot), obs() & e.mask, e.val & e.mask);
    end
  end

  task automatic drive_step(input int x1, input int y1, input int x2, input int y2,
                            input bit al1, input bit al2);
    p1_x = 8'(x1); p1_y = 7'(y1); p2_x = 8'(x2); p2_y = 7'(y2);
    p1_alive = al1; p2_alive = al2;
    step = 1'b1;
  endtask

  task automatic run_step(input int id, input int x1, input int y1, input int x2, input int y2,
                          input bit al1, input bit al2);
    drive_step(x1, y1, x2, y2, al1, al2);
    push_step(id, cyc, x1, y1, x2, y2, al1, al2, 5'b0, 1'b1);
    @(negedge clk);
    step = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20000 && busy; k++) @(negedge clk);
    check_eq(tag, obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish by 2000000");
    $fatal(1, "timeout");
  end

  initial begin : main
    int bad, first_bad, t;
    resetn = 1'b0; step = 1'b0; clear_req = 1'b0;
    p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0; p1_alive = 1'b0; p2_alive = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Power-up sweep, with a step pulse that must be ignored.
    resetn = 1'b1;
    @(negedge clk);
    bad = 0; first_bad = -1;
    for (int i = 0; i < 19200; i++) begin
      step = (i == 100);
      if (obs() !== pk(i, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      @(negedge clk);
    end
    step = 1'b0;
    check_eq("sweep_bad_cycles", bad, 0);
    if (bad != 0) check_eq("sweep_first_bad", first_bad, -1);
    check_eq("post_sweep_idle", obs(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    run_step(1, 10, 5, 20, 5, 1, 1);
    run_step(2, 160, 0, 159, 119, 1, 1);
    run_step(3, 50, 60, 50, 60, 1, 1);
    run_step(4, 3, 119, 7, 2, 1, 0);
    run_step(5, 0, 120, 255, 127, 1, 1);

    // Step while busy sets overrun; clear_req while busy defers a sweep to after WR2.
    t = cyc;
    drive_step(1, 1, 2, 2, 1, 1);
    push_step(6, t, 1, 1, 2, 2, 1, 1, 5'b11100, 1'b0);
    push(t + 6, 6, 6, pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), '1);
    push(t + 7, 6, 7, pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), '1);
    @(negedge clk); step = 1'b0;
    @(negedge clk); drive_step(30, 30, 40, 40, 1, 1);
    @(negedge clk); step = 1'b0; clear_req = 1'b1;
    @(negedge clk); clear_req = 1'b0;
    repeat (50) @(negedge clk);
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    wait_idle("idle_after_deferred_clear");

    // clear_req and step together in IDLE: clear wins.
    t = cyc;
    drive_step(5, 5, 6, 6, 1, 1);
    clear_req = 1'b1;
    push(t + 1, 7, 1, pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), '1);
    push(t + 2, 7, 2, pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), '1);
    @(negedge clk); step = 1'b0; clear_req = 1'b0;
    wait_idle("idle_after_simultaneous");

    run_step(8, 159, 0, 0, 119, 1, 1);
    repeat (3) @(negedge clk);
    check_eq("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
